// File: rtl/picorv_mem_arbiter_pkg.sv
// Shared types and constants for the two-port PicoRV native-memory arbiter.
// DRAIN is only reachable when PICORV_ARB_TIMEOUT_EN is defined.
package picorv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv_mem_arbiter_if.sv
// PicoRV native memory handshake bundle; master issues requests, slave completes them.
interface picorv_mem_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, instr, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picorv_mem_arbiter_pick2.sv
// Combinational two-way winner selection: round-robin on rr_ptr_i or fixed priority to the core port.
module picorv_arb_pick2
  import picorv_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  output logic       any_o,
  output logic       win_o
);

  always_comb begin
    any_o = |valid_i;
    win_o = PORT_CORE;
    case (valid_i)
      2'b10:   win_o = PORT_AUX;
      2'b11:   win_o = RR_EN ? rr_ptr_i : PORT_CORE;
      default: win_o = PORT_CORE;
    endcase
  end

endmodule

// File: rtl/picorv_mem_arbiter.sv
// Two-requester arbiter onto one PicoRV native memory port; latches the winner until completion.
// Define PICORV_ARB_TIMEOUT_EN to add the GRANT watchdog, the DRAIN state and err_timeout.
module picorv_mem_arbiter
  import picorv_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
`ifdef PICORV_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
  , parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
`endif
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  picorv_mem_arbiter_if.slave   s0,
  picorv_mem_arbiter_if.slave   s1,
  picorv_mem_arbiter_if.master  m,
  output logic [1:0]            grant,
  output logic                  busy
`ifdef PICORV_ARB_TIMEOUT_EN
  , output logic                err_timeout
`endif
);

  arb_state_e  state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        owner_q, owner_d;
  logic [1:0]  grant_q, grant_d;
  logic        m_valid_q, m_valid_d;
  logic        m_instr_q, m_instr_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic [1:0]  rdy;
  logic [31:0] s_rdata;
  logic        pick_any, pick_win;

`ifdef PICORV_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  picorv_arb_pick2 #(.RR_EN(RR_EN)) u_pick (
    .valid_i  ({s1.valid, s0.valid}),
    .rr_ptr_i (rr_ptr_q),
    .any_o    (pick_any),
    .win_o    (pick_win)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= IDLE;
      rr_ptr_q  <= PORT_CORE;
      owner_q   <= PORT_CORE;
      grant_q   <= 2'b00;
      m_valid_q <= 1'b0;
      m_instr_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
`ifdef PICORV_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_instr_q <= m_instr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
`ifdef PICORV_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    rdy       = 2'b00;
    s_rdata   = '0;
`ifdef PICORV_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = GRANT;
          owner_d   = pick_win;
          m_valid_d = 1'b1;
          grant_d   = pick_win ? 2'b10 : 2'b01;
          m_instr_d = pick_win ? s1.instr : s0.instr;
          m_addr_d  = pick_win ? s1.addr  : s0.addr;
          m_wdata_d = pick_win ? s1.wdata : s0.wdata;
          m_wstrb_d = pick_win ? s1.wstrb : s0.wstrb;
`ifdef PICORV_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      GRANT: begin
        s_rdata = m.rdata;
        // A real completion in the limit cycle takes precedence over the timeout.
        if (m.ready) begin
          rdy[owner_q] = 1'b1;
          state_d      = IDLE;
          m_valid_d    = 1'b0;
          grant_d      = 2'b00;
          if (RR_EN) rr_ptr_d = ~owner_q;
        end
`ifdef PICORV_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rdy[owner_q] = 1'b1;
          s_rdata      = ERR_RDATA;
          err_d        = 1'b1;
          state_d      = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
`ifdef PICORV_ARB_TIMEOUT_EN
      DRAIN: begin
        // The late response belongs to a request the owner already saw fail; swallow it.
        if (m.ready) begin
          state_d   = IDLE;
          m_valid_d = 1'b0;
          grant_d   = 2'b00;
          if (RR_EN) rr_ptr_d = ~owner_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign m.valid  = m_valid_q;
  assign m.instr  = m_instr_q;
  assign m.addr   = m_addr_q;
  assign m.wdata  = m_wdata_q;
  assign m.wstrb  = m_wstrb_q;
  assign s0.ready = rdy[PORT_CORE];
  assign s1.ready = rdy[PORT_AUX];
  assign s0.rdata = s_rdata;
  assign s1.rdata = s_rdata;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
`ifdef PICORV_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`endif

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Scoreboard bench for picorv_mem_arbiter; timeout cases run when PICORV_ARB_TIMEOUT_EN is defined.
module tb_picorv_mem_arbiter;
  import picorv_arb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  picorv_mem_arbiter_if s0_if ();
  picorv_mem_arbiter_if s1_if ();
  picorv_mem_arbiter_if m_if ();
  logic [1:0] grant;
  logic       busy;

  picorv_mem_arbiter_if fp_s0 ();
  picorv_mem_arbiter_if fp_s1 ();
  picorv_mem_arbiter_if fp_m ();
  logic [1:0] fp_grant;
  logic       fp_busy;

`ifdef PICORV_ARB_TIMEOUT_EN
  logic err_timeout, fp_err;
`endif

  picorv_mem_arbiter #(
    .RR_EN(1'b1)
`ifdef PICORV_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .s0     (s0_if),
    .s1     (s1_if),
    .m      (m_if),
    .grant  (grant),
    .busy   (busy)
`ifdef PICORV_ARB_TIMEOUT_EN
    , .err_timeout (err_timeout)
`endif
  );

  // Fixed-priority copy sees the same requesters and an adapter that answers at once.
  picorv_mem_arbiter #(
    .RR_EN(1'b0)
`ifdef PICORV_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut_fp (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .s0     (fp_s0),
    .s1     (fp_s1),
    .m      (fp_m),
    .grant  (fp_grant),
    .busy   (fp_busy)
`ifdef PICORV_ARB_TIMEOUT_EN
    , .err_timeout (fp_err)
`endif
  );

  assign fp_s0.valid = s0_if.valid;
  assign fp_s0.instr = s0_if.instr;
  assign fp_s0.addr  = s0_if.addr;
  assign fp_s0.wdata = s0_if.wdata;
  assign fp_s0.wstrb = s0_if.wstrb;
  assign fp_s1.valid = s1_if.valid;
  assign fp_s1.instr = s1_if.instr;
  assign fp_s1.addr  = s1_if.addr;
  assign fp_s1.wdata = s1_if.wdata;
  assign fp_s1.wstrb = s1_if.wstrb;
  assign fp_m.ready  = fp_m.valid;
  assign fp_m.rdata  = 32'h0;

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } req_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic fp_chk      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic v, input logic ins,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    if (port) begin
      s1_if.valid = v; s1_if.instr = ins; s1_if.addr = a; s1_if.wdata = wd; s1_if.wstrb = ws;
    end else begin
      s0_if.valid = v; s0_if.instr = ins; s0_if.addr = a; s0_if.wdata = wd; s0_if.wstrb = ws;
    end
  endtask

  task automatic expect_txn(input logic port, input logic ins, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd);
    exp_req.push_back('{grant: port ? 2'b10 : 2'b01, addr: a, wdata: wd, wstrb: ws, instr: ins});
    exp_rsp.push_back('{port: port, rdata: rd});
  endtask

  // Adapter: wait (bounded) for a request, hold off lat cycles, then pulse m_ready once.
  task automatic serve(input int lat, input logic [31:0] rd);
    int guard = 0;
    while (!m_if.valid && guard < 50) begin
      @(posedge HCLK); #1;
      guard++;
    end
    chk("serve_wait_m_valid", 32'(m_if.valid), 32'd1);
    repeat (lat) begin @(posedge HCLK); #1; end
    m_if.ready = 1'b1;
    m_if.rdata = rd;
    @(posedge HCLK); #1;
    m_if.ready = 1'b0;
    m_if.rdata = 32'h0;
  endtask

  initial begin
    HRESET = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m_if.ready = 1'b0;
    m_if.rdata = 32'h0;

    fork
      begin : monitor
        logic        mv_prev;
        logic [31:0] cur_addr;
        req_t        e;
        rsp_t        r;
        mv_prev  = 1'b0;
        cur_addr = 32'h0;
        forever begin
          @(negedge HCLK);
          if (m_if.valid && !mv_prev) begin
            if (exp_req.size() == 0) begin
              chk("unexpected_request_addr", m_if.addr, 32'hxxxx_xxxx);
            end else begin
              e = exp_req.pop_front();
              chk("req_grant", 32'(grant), 32'(e.grant));
              chk("req_addr",  m_if.addr,  e.addr);
              chk("req_wdata", m_if.wdata, e.wdata);
              chk("req_wstrb", 32'(m_if.wstrb), 32'(e.wstrb));
              chk("req_instr", 32'(m_if.instr), 32'(e.instr));
              cur_addr = e.addr;
            end
          end
          if (s0_if.ready || s1_if.ready) begin
            if (exp_rsp.size() == 0) begin
              chk("unexpected_ready", {30'b0, s1_if.ready, s0_if.ready}, 32'd0);
            end else begin
              r = exp_rsp.pop_front();
              chk("rsp_ready_onehot", {30'b0, s1_if.ready, s0_if.ready}, r.port ? 32'd2 : 32'd1);
              chk("rsp_rdata", r.port ? s1_if.rdata : s0_if.rdata, r.rdata);
              chk("rsp_addr_held", m_if.addr, cur_addr);
            end
          end
          mv_prev = m_if.valid;
        end
      end
      begin : fp_monitor
        forever begin
          @(negedge HCLK);
          if (fp_chk && fp_m.valid) begin
            chk("fp_grant_core", 32'(fp_grant), 32'd1);
            chk("fp_aux_ready", 32'(fp_s1.ready), 32'd0);
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
      end
    join_none

    // Reset state
    repeat (2) @(negedge HCLK);
    chk("rst_m_valid", 32'(m_if.valid), 32'd0);
    chk("rst_grant",   32'(grant), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_ready",   {30'b0, s1_if.ready, s0_if.ready}, 32'd0);
    chk("rst_rdata",   s0_if.rdata, 32'd0);
    chk("rst_m_addr",  m_if.addr, 32'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Single read from the core port, adapter answers after 3 cycles
    expect_txn(1'b0, 1'b0, 32'h4000_0000, 32'h0, 4'h0, 32'h1234_5678);
    drive(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
    @(posedge HCLK); #1;
    chk("read_latency_1", 32'(m_if.valid), 32'd1);
    serve(3, 32'h1234_5678);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("read_done_m_valid", 32'(m_if.valid), 32'd0);
    chk("read_done_grant", 32'(grant), 32'd0);

    // Field stability, plus a non-owner request arriving while busy
    expect_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFE_0001);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(posedge HCLK); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h5555_5555, 4'hF);
    expect_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h1111_0000);
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    @(posedge HCLK); #1;
    chk("stable_addr", m_if.addr, 32'h10);
    chk("stable_grant", 32'(grant), 32'd1);
    @(posedge HCLK); #1;
    chk("stable_addr_late", m_if.addr, 32'h10);
    m_if.ready = 1'b1;
    m_if.rdata = 32'hCAFE_0001;
    @(posedge HCLK); #1;
    m_if.ready = 1'b0;
    m_if.rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("idle_gap_m_valid", 32'(m_if.valid), 32'd0);
    serve(0, 32'h1111_0000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Partial write from the aux port
    expect_txn(1'b1, 1'b0, 32'h2000_0008, 32'hAABB_CCDD, 4'b0011, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h2000_0008, 32'hAABB_CCDD, 4'b0011);
    @(posedge HCLK); #1;
    chk("wr_wstrb", 32'(m_if.wstrb), 32'h3);
    chk("wr_wdata", m_if.wdata, 32'hAABB_CCDD);
    serve(1, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Instruction fetch, immediate adapter response
    expect_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0013);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    serve(0, 32'h0000_0013);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // m_ready while idle produces no requester ready
    m_if.ready = 1'b1;
    m_if.rdata = 32'hFFFF_FFFF;
    @(negedge HCLK);
    chk("idle_mready_no_ready", {30'b0, s1_if.ready, s0_if.ready}, 32'd0);
    chk("idle_mready_rdata", s0_if.rdata, 32'd0);
    @(posedge HCLK); #1;
    m_if.ready = 1'b0;
    m_if.rdata = 32'h0;
    chk("idle_mready_busy", 32'(busy), 32'd0);

    // Contention from reset release: round-robin alternates, fixed priority keeps port 0
    HRESET = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_00B0, 32'h0, 4'h0);
    fp_chk = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_txn(i[0], 1'b0, i[0] ? 32'h0000_00B0 : 32'h0000_00A0, 32'h0, 4'h0, 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) serve(0, 32'(i + 1));
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge HCLK); #1;
    fp_chk = 1'b0;
    @(posedge HCLK); #1;

    // Reset in the middle of a GRANT
    exp_req.push_back('{grant: 2'b01, addr: 32'h55, wdata: 32'h0, wstrb: 4'h0, instr: 1'b0});
    drive(1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 4'h0);
    @(posedge HCLK); #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    @(negedge HCLK); #1;
    HRESET = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_if.valid), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    expect_txn(1'b1, 1'b0, 32'h66, 32'h77, 4'hF, 32'h5);
    drive(1'b1, 1'b1, 1'b0, 32'h66, 32'h77, 4'hF);
    @(posedge HCLK); #1;
    chk("postrst_latency_1", 32'(m_if.valid), 32'd1);
    serve(2, 32'h5);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

`ifdef PICORV_ARB_TIMEOUT_EN
    // Adapter never answers: error completion at GRANT cycle 8, late m_ready swallowed
    chk("to_err_clear", 32'(err_timeout), 32'd0);
    expect_txn(1'b0, 1'b0, 32'h77, 32'h0, 4'h0, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 4'h0);
    @(posedge HCLK); #1;
    repeat (6) begin @(posedge HCLK); #1; end
    chk("to_no_ready_cycle7", 32'(s0_if.ready), 32'd0);
    @(posedge HCLK); #1;
    chk("to_ready_cycle8", 32'(s0_if.ready), 32'd1);
    chk("to_err_rdata", s0_if.rdata, 32'hDEAD_BEEF);
    @(posedge HCLK); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("to_err_sticky", 32'(err_timeout), 32'd1);
    chk("to_drain_m_valid", 32'(m_if.valid), 32'd1);
    chk("to_drain_grant", 32'(grant), 32'd1);
    chk("to_drain_busy", 32'(busy), 32'd1);
    @(posedge HCLK); #1;
    m_if.ready = 1'b1;
    m_if.rdata = 32'h9999_9999;
    #1;
    chk("to_swallow", {30'b0, s1_if.ready, s0_if.ready}, 32'd0);
    @(posedge HCLK); #1;
    m_if.ready = 1'b0;
    m_if.rdata = 32'h0;
    chk("to_back_idle", 32'(busy), 32'd0);
    chk("to_back_m_valid", 32'(m_if.valid), 32'd0);
    chk("to_err_still_set", 32'(err_timeout), 32'd1);
`endif

    repeat (3) @(posedge HCLK);
    #1;
    chk("scoreboard_req_left", 32'(exp_req.size()), 32'd0);
    chk("scoreboard_rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/picorv_mem_arbiter.md
Name: picorv_mem_arbiter

Overview:
- Two-requester arbiter for the PicoRV native memory interface.
- Port 0 is the picorv32 core; port 1 is a secondary master such as a debug loader or DMA.
- Merges both requesters onto the single native-memory input of the FreeAHB adapter, so both share one AHB master.
- Latches the winning request, holds it stable until the downstream completes, then rotates priority.

Parameters:
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- TIMEOUT_CYCLES, 1024, watchdog limit in HCLK cycles; used only with the optional feature.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out request; optional feature only.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous active-high reset.
- s0_valid/s1_valid  in  1  request valid; held until the matching ready.
- s0_instr/s1_instr  in  1  instruction-fetch flag.
- s0_addr/s1_addr  in  32  byte address.
- s0_wdata/s1_wdata  in  32  write data.
- s0_wstrb/s1_wstrb  in  4  byte strobes; 0 = read.
- s0_ready/s1_ready  out  1  one-cycle completion pulse.
- s_rdata  out  32  read data, broadcast to both ports; valid while sN_ready=1.
- m_valid  out  1  registered request to the adapter.
- m_instr  out  1  latched instr flag.
- m_addr  out  32  latched address.
- m_wdata  out  32  latched write data.
- m_wstrb  out  4  latched byte strobes.
- m_ready  in  1  adapter completion.
- m_rdata  in  32  adapter read data.
- grant  out  2  one-hot owner; 00 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-transfer):
  - state=IDLE, rr_ptr=0.
  - m_valid=0; m_addr, m_wdata, m_wstrb, m_instr=0.
  - grant=00, busy=0, s0_ready=s1_ready=0, s_rdata=0.
  - A transfer in flight at the adapter is abandoned; the adapter is reset by the same reset.
- States:
  - IDLE: no owner.
  - GRANT: request issued downstream.
  - DRAIN: timed-out request still outstanding; exists only with the optional feature.
- IDLE, arbitration:
  - Samples s0_valid and s1_valid each cycle.
  - One valid: that port wins.
  - Both valid, RR_EN=1: port rr_ptr wins. RR_EN=0: port 0 wins.
  - On a win, the next edge latches the winner's addr/wdata/wstrb/instr into m_*, sets m_valid=1, sets grant one-hot, and enters GRANT.
  - Latency: requester valid to m_valid is exactly 1 cycle.
- GRANT:
  - m_* and grant are frozen even if the owner drops valid or changes fields; the owner is never aborted.
  - sOwner_ready = m_ready, combinational. The non-owner's ready is always 0.
  - s_rdata = m_rdata.
  - On m_ready: next edge sets m_valid=0, grant=00, state=IDLE. With RR_EN=1, rr_ptr becomes the port that did not just complete.
- Back-to-back:
  - After completion there is one mandatory IDLE cycle.
  - Minimum request-to-ready for an immediate adapter response is 2 cycles.
  - A requester re-asserting valid in the cycle after its ready competes normally.
- Starvation: with RR_EN=1 and both ports continuously requesting, grants alternate 0,1,0,1.
- Non-owner's request: ignored while busy and never latched until its own IDLE win.
- m_ready while IDLE: ignored; no sN_ready is generated.

Optional Feature:
- Macro: PICORV_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to GRANT and increments every GRANT cycle without m_ready.
  - When it reaches TIMEOUT_CYCLES-1, the owner's ready pulses for one cycle with s_rdata=ERR_RDATA, and a sticky output err_timeout (1 bit, cleared only by reset) sets.
  - State moves to DRAIN: m_valid stays 1, grant stays set, no sN_ready is generated.
  - In DRAIN, the first m_ready is swallowed (no requester ready), then state=IDLE and rr_ptr rotates as in GRANT.
  - m_ready in the same cycle the counter reaches the limit: the normal completion wins, no error.
- Undefined: no counter, no DRAIN state, no err_timeout port; GRANT waits indefinitely.

Decomposition:
- Package picorv_arb_pkg contains:
  - state enum (IDLE, GRANT, DRAIN);
  - port index constants PORT_CORE=0, PORT_AUX=1;
  - default ERR_RDATA value.
- One sub-module, picorv_arb_pick2: combinational winner selection from the two valids, rr_ptr and RR_EN.

Test Plan:
- Single read: s0 reads 0x4000_0000 and the adapter returns 0x1234_5678 after 3 cycles -> m_valid 1 cycle after s0_valid, addr 0x4000_0000, s0_ready one pulse with s_rdata=0x1234_5678, s1_ready stays 0.
- Contention: both valid at reset release with RR_EN=1 -> grant order 01,10,01,10 over 4 transactions; with RR_EN=0 -> port 0 always wins while it keeps requesting.
- Field stability: the owner changes s0_addr from 0x10 to 0x20 mid-GRANT -> m_addr stays 0x10 until m_ready.
- Write strobes: s1 writes wdata 0xAABBCCDD with wstrb 4'b0011 -> m_wstrb=0011, m_wdata matches, s1_ready pulses once.
- Reset mid-transfer: HRESET asserted in GRANT -> m_valid, grant and busy fall asynchronously before the next edge; the first post-reset request is granted normally.
- Timeout (macro defined, TIMEOUT_CYCLES=8): the adapter never responds -> owner ready at cycle 8 of GRANT with s_rdata=0xDEAD_BEEF, err_timeout=1; a late m_ready is swallowed and the block returns to IDLE.
